// File: rtl/serial_deserializer_if.sv
// serial_deserializer_if: valid/ready word port carrying one deserialized word
interface serial_deserializer_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] Qout;
    logic             q_valid;
    logic             q_ready;
    modport master (output Qout, output q_valid, input q_ready);
    modport slave (input Qout, input q_valid, output q_ready);
endinterface

// File: rtl/serial_deserializer.sv
// serial_deserializer: collects WIDTH enabled serial bits into words on a valid/ready port
module serial_deserializer #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  Din,
    input  logic                  sync,
    serial_deserializer_if.master q,
    output logic                  overrun,
    input  logic                  clr_overrun,
    output logic [CW-1:0]         bit_cnt
);
    logic [WIDTH-1:0] sh, sh_next, word;
    logic [CW-1:0]    cnt_eff;
    logic             valid, done, hs, drop;
    assign q.Qout    = word;
    assign q.q_valid = valid;
    // sync restarts the frame by treating the current count as zero
    assign cnt_eff = sync ? '0 : bit_cnt;
    assign sh_next = LSB_FIRST ? {Din, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], Din};
    assign done    = enable && cnt_eff == CW'(WIDTH - 1);
    assign hs      = valid && q.q_ready;
    assign drop    = done && valid && !q.q_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            sh      <= '0;
            bit_cnt <= '0;
            word    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (enable) begin
                sh      <= sh_next;
                bit_cnt <= done ? '0 : cnt_eff + CW'(1);
            end else if (sync) begin
                bit_cnt <= '0;
            end
            if (done && !drop) begin
                word  <= sh_next;
                valid <= 1'b1;
            end else if (hs) begin
                valid <= 1'b0;
            end
            overrun <= drop || (overrun && !clr_overrun);
        end
    end
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed checks on 8-bit MSB/LSB-first and 16-bit instances
module tb_serial_deserializer;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, Din = 1'b0, sync = 1'b0;
    logic q_ready = 1'b1, clr_overrun = 1'b0;
    logic ov8m, ov8l, ov16;
    logic [2:0] bc8m, bc8l;
    logic [3:0] bc16;
    int passed = 0, total = 0;

    serial_deserializer_if #(.WIDTH(8))  i8m ();
    serial_deserializer_if #(.WIDTH(8))  i8l ();
    serial_deserializer_if #(.WIDTH(16)) i16 ();
    assign i8m.q_ready = q_ready;
    assign i8l.q_ready = q_ready;
    assign i16.q_ready = q_ready;

    serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) d8m (.clk(clk), .reset(reset), .enable(enable),
        .Din(Din), .sync(sync), .q(i8m), .overrun(ov8m), .clr_overrun(clr_overrun), .bit_cnt(bc8m));
    serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) d8l (.clk(clk), .reset(reset), .enable(enable),
        .Din(Din), .sync(sync), .q(i8l), .overrun(ov8l), .clr_overrun(clr_overrun), .bit_cnt(bc8l));
    serial_deserializer #(.WIDTH(16), .LSB_FIRST(1'b0)) d16 (.clk(clk), .reset(reset), .enable(enable),
        .Din(Din), .sync(sync), .q(i16), .overrun(ov16), .clr_overrun(clr_overrun), .bit_cnt(bc16));

    always #5 clk = ~clk;

    task automatic cyc(input logic e, input logic d, input logic s);
        enable = e;
        Din = d;
        sync = s;
        @(posedge clk);
        #1;
        enable = 1'b0;
        sync = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) cyc(1, w[i], 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        reset = 1'b0;
        total++; if (i8m.Qout !== 8'h00) $display("FAIL reset_qout got=%h exp=00", i8m.Qout); else passed++;
        total++; if (i8m.q_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", i8m.q_valid); else passed++;
        total++; if (ov8m !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", ov8m); else passed++;
        total++; if (bc16 !== 4'd0) $display("FAIL reset_bitcnt got=%0d exp=0", bc16); else passed++;
    endtask

    task automatic test_bit_order();
        logic [7:0] s;
        s = 8'b1100_0000;
        q_ready = 1'b1;
        for (int i = 7; i >= 1; i--) cyc(1, s[i], 0);
        total++; if (i8m.q_valid !== 1'b0) $display("FAIL early_valid got=%b exp=0", i8m.q_valid); else passed++;
        cyc(1, s[0], 0);
        total++; if (i8m.Qout !== 8'hC0) $display("FAIL msb_qout got=%h exp=c0", i8m.Qout); else passed++;
        total++; if (i8l.Qout !== 8'h03) $display("FAIL lsb_qout got=%h exp=03", i8l.Qout); else passed++;
        total++; if (i8m.q_valid !== 1'b1) $display("FAIL msb_valid got=%b exp=1", i8m.q_valid); else passed++;
        total++; if (bc8m !== 3'd0) $display("FAIL msb_bitcnt got=%0d exp=0", bc8m); else passed++;
        cyc(0, 0, 0);
        total++; if (i8m.q_valid !== 1'b0) $display("FAIL valid_pulse got=%b exp=0", i8m.q_valid); else passed++;
    endtask

    task automatic test_enable_gaps();
        logic [15:0] w;
        w = 16'hA5F0;
        do_reset();
        q_ready = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            int gap;
            gap = int'($urandom_range(3));
            for (int g = 0; g < gap; g++) cyc(0, ~w[i], 0);
            total++; if (bc16 !== 4'(15 - i)) $display("FAIL gap_bitcnt got=%0d exp=%0d", bc16, 15 - i); else passed++;
            cyc(1, w[i], 0);
        end
        total++; if (i16.Qout !== 16'hA5F0) $display("FAIL gap_qout got=%h exp=a5f0", i16.Qout); else passed++;
        total++; if (i16.q_valid !== 1'b1) $display("FAIL gap_valid got=%b exp=1", i16.q_valid); else passed++;
    endtask

    task automatic test_sync_overrun();
        do_reset();
        q_ready = 1'b0;
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        total++; if (bc8m !== 3'd1) $display("FAIL sync_bitcnt got=%0d exp=1", bc8m); else passed++;
        for (int i = 0; i < 7; i++) cyc(1, (i % 2 == 1), 0);
        total++; if (i8m.Qout !== 8'hAA) $display("FAIL sync_qout got=%h exp=aa", i8m.Qout); else passed++;
        total++; if (ov8m !== 1'b0) $display("FAIL sync_overrun got=%b exp=0", ov8m); else passed++;
        send_byte(8'hFF);
        total++; if (ov8m !== 1'b1) $display("FAIL overrun_set got=%b exp=1", ov8m); else passed++;
        total++; if (i8m.Qout !== 8'hAA) $display("FAIL overrun_qout got=%h exp=aa", i8m.Qout); else passed++;
        total++; if (i8m.q_valid !== 1'b1) $display("FAIL overrun_valid got=%b exp=1", i8m.q_valid); else passed++;
        cyc(0, 0, 0);
        total++; if (ov8m !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", ov8m); else passed++;
        clr_overrun = 1'b1;
        cyc(0, 0, 0);
        clr_overrun = 1'b0;
        total++; if (ov8m !== 1'b0) $display("FAIL overrun_clr got=%b exp=0", ov8m); else passed++;
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 1);
        total++; if (bc8m !== 3'd0) $display("FAIL sync_idle_bitcnt got=%0d exp=0", bc8m); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        do_reset();
        q_ready = 1'b0;
        send_byte(8'h3C);
        total++; if (i8m.Qout !== 8'h3C) $display("FAIL b2b_w1 got=%h exp=3c", i8m.Qout); else passed++;
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) cyc(1, w[i], 0);
        q_ready = 1'b1;
        cyc(1, w[0], 0);
        total++; if (i8m.q_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", i8m.q_valid); else passed++;
        total++; if (i8m.Qout !== 8'h5A) $display("FAIL b2b_w2 got=%h exp=5a", i8m.Qout); else passed++;
        total++; if (ov8m !== 1'b0) $display("FAIL b2b_overrun got=%b exp=0", ov8m); else passed++;
        w = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            cyc(1, w[i], 0);
            if (i == 7) begin
                total++; if (i8m.q_valid !== 1'b0) $display("FAIL b2b_drop got=%b exp=0", i8m.q_valid); else passed++;
            end
        end
        total++; if (i8m.Qout !== 8'h96) $display("FAIL b2b_w3 got=%h exp=96", i8m.Qout); else passed++;
        cyc(1, 0, 0);
        total++; if (i8m.q_valid !== 1'b0) $display("FAIL b2b_pulse got=%b exp=0", i8m.q_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        q_ready = 1'b0;
        send_byte(8'hFF);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);
        reset = 1'b1;
        cyc(1, 1, 0);
        reset = 1'b0;
        total++; if (i8m.Qout !== 8'h00) $display("FAIL mid_qout got=%h exp=00", i8m.Qout); else passed++;
        total++; if (i8m.q_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", i8m.q_valid); else passed++;
        total++; if (bc8m !== 3'd0) $display("FAIL mid_bitcnt got=%0d exp=0", bc8m); else passed++;
        total++; if (ov8m !== 1'b0) $display("FAIL mid_overrun got=%b exp=0", ov8m); else passed++;
        send_byte(8'h81);
        total++; if (i8m.Qout !== 8'h81) $display("FAIL mid_word got=%h exp=81", i8m.Qout); else passed++;
        total++; if (i8l.Qout !== 8'h81) $display("FAIL mid_word_lsb got=%h exp=81", i8l.Qout); else passed++;
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_enable_gaps();
        test_sync_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Parametrised serial-to-parallel deserializer that collects WIDTH enabled serial bits into a word and presents each completed word on a valid/ready output port. It replaces the fixed 16-bit shifter, which used a negative-edge output register. Bit order is selectable, and frame alignment comes from an explicit sync input. Overflow is reported through a sticky overrun flag. It sits between a serial input pin (or an upstream bit-serial source) and a word-wide consumer.

## Interface
- WIDTH, 16, word width in bits; legal range 2..64.
- LSB_FIRST, 0, bit order: 0 = first received bit lands in Qout[WIDTH-1]; 1 = first received bit lands in Qout[0].
- CW, $clog2(WIDTH), bit counter width (derived; do not override).

Ports:
- clk  in  1  single rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  Din is sampled on this cycle's rising edge when 1.
- Din  in  1  serial data bit.
- sync  in  1  frame restart: discard any partial word; this cycle's Din (if enabled) is bit 0 of a new word.
- Qout  out  WIDTH  last accepted word.
- q_valid  out  1  Qout holds a word not yet taken.
- q_ready  in  1  consumer accepts Qout when q_valid && q_ready.
- overrun  out  1  sticky: a completed word was dropped.
- clr_overrun  in  1  clears overrun.
- bit_cnt  out  CW  bits collected in the current partial word (0..WIDTH-1).

## Operation
- Internal shift register sh[WIDTH-1:0].
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], Din}.
  - LSB_FIRST=1: sh <= {Din, sh[WIDTH-1:1]}.
- Enabled sample (enable=1): shift Din in.
  - If bit_cnt == WIDTH-1, the word is complete and bit_cnt wraps to 0.
  - Otherwise bit_cnt increments.
- sync=1: treat bit_cnt as 0 before the sample.
  - With enable=1, bit_cnt <= 1 and any partial word is discarded.
  - With enable=0, bit_cnt <= 0.
  - No flag is raised. sync at bit_cnt=0 is a no-op.
- Word completion: the completed word is the next value of sh, with Din included.
  - If q_valid=0, or a handshake occurs in the same cycle: Qout <= word, q_valid <= 1.
  - Otherwise (q_valid=1, q_ready=0): the word is dropped, Qout is unchanged, overrun <= 1.
- Handshake without completion: q_valid <= 0. Qout holds its value.
- overrun: cleared by clr_overrun. If a set and a clear occur in the same cycle, set wins.
- enable=0 and sync=0: sh, bit_cnt, Qout and overrun hold. The handshake still operates.

## Timing
- Reset values: sh=0, bit_cnt=0, Qout=0, q_valid=0, overrun=0.
  - Reset overrides all other inputs.
  - Reset mid-word discards the partial word.
  - Reset with q_valid=1 drops the pending word with no flag.
- Latency: the edge that samples the WIDTH-th bit also loads Qout and asserts q_valid, so q_valid is high in the following cycle.
- Back-to-back words:
  - Continuous enable gives one word every WIDTH cycles.
  - With q_ready tied high, q_valid pulses for 1 cycle per word.
  - Completion plus handshake in the same cycle keeps q_valid=1 with the new data.
- q_valid is never deasserted without a handshake or reset. Qout is stable while q_valid=1.
- bit_cnt, overrun and q_valid are registered outputs; there are no combinational input-to-output paths.
- enable gaps of any length between bits do not affect assembly.

## Test plan
- MSB-first load, WIDTH=8, LSB_FIRST=0, q_ready=1:
  - Stimulus: reset 2 cycles, then 8 enabled bits 1,1,0,0,0,0,0,0.
  - Required: Qout=8'hC0, q_valid high exactly 1 cycle, in the cycle after the 8th bit. bit_cnt ends at 0.
- LSB-first load, WIDTH=8, LSB_FIRST=1:
  - Stimulus: same stream as above.
  - Required: Qout=8'h03.
- Enable gaps, WIDTH=16, LSB_FIRST=0:
  - Stimulus: bits of 16'hA5F0 MSB-first, with enable low for random 0–3 cycles between bits.
  - Required: Qout=16'hA5F0, bit_cnt counts 0..15 with no skips.
- Sync and overrun, WIDTH=8, q_ready=0:
  - Stimulus: 3 bits, then sync with enable=1 and Din=1, then 7 more bits 0,1,0,1,0,1,0.
  - Required: Qout=8'hAA (LSB_FIRST=0), no overrun.
  - Continue: stream 8 more bits with q_ready still 0.
  - Required: overrun=1, Qout stays 8'hAA.
  - Continue: pulse clr_overrun.
  - Required: overrun=0.
- Simultaneous completion and handshake, WIDTH=8:
  - Stimulus: hold q_ready=0 until the 2nd word completes, with q_ready=1 on that same edge.
  - Required: q_valid stays 1, Qout switches to word 2, overrun=0.
- Reset mid-word:
  - Stimulus: after 5 bits plus a pending q_valid, assert reset 1 cycle, then send 8 bits of 8'h81.
  - Required: outputs all 0 after reset, and the next word is 8'h81.
